// File: rtl/ins_fetch_ctrl_if.sv
// Loader, instruction-memory and core-side signals of the fetch controller.
// master = controller side, slave = loader/memory/core environment.
interface ins_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              branch;
  logic [ADDR_W-1:0] branch_addr;
  logic              halt;
  logic              restart;
  logic [DATA_W-1:0] instruction;
  logic              ins_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   load_count;
  logic              load_ovf;
  logic              running;
  logic              halted;

  modport master (
    input  load_valid, load_data, mem_rdata, stall, branch, branch_addr, halt, restart,
    output load_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           instruction, ins_valid, pc, load_count, load_ovf, running, halted
  );

  modport slave (
    output load_valid, load_data, mem_rdata, stall, branch, branch_addr, halt, restart,
    input  load_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           instruction, ins_valid, pc, load_count, load_ovf, running, halted
  );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// Instruction-fetch controller: loads memory until terminator, then fetches by PC.
// Latency: fetch 1 cycle, branch 1 bubble; backpressure: stall freezes PC/instruction, load_ready high only in LOAD.
module ins_fetch_ctrl #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] TERM   = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  ins_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic              vld_q, vld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ins_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ins_d   = ins_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_LOAD: begin
        vld_d = 1'b0;
        if (bus.load_valid) begin
          cnt_d = cnt_q + (ADDR_W + 1)'(1);
          // Terminator wins over overflow when it lands in the last slot.
          if (bus.load_data == TERM) begin
            state_d = ST_RUN;
            pc_d    = '0;
          end else if (cnt_q[ADDR_W-1:0] == '1) begin
            ovf_d   = 1'b1;
            state_d = ST_RUN;
            pc_d    = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_HALTED;
          vld_d   = 1'b0;
        end else if (bus.branch) begin
          pc_d  = bus.branch_addr;
          vld_d = 1'b0;
        end else if (!bus.stall) begin
          ins_d = bus.mem_rdata;
          vld_d = 1'b1;
          pc_d  = pc_q + ADDR_W'(1);
        end
      end
      ST_HALTED: begin
        vld_d = 1'b0;
        if (bus.restart) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          pc_d    = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.mem_we      = (state_q == ST_LOAD) && bus.load_valid;
  assign bus.mem_waddr   = cnt_q[ADDR_W-1:0];
  assign bus.mem_wdata   = bus.load_data;
  assign bus.mem_raddr   = pc_q;
  assign bus.instruction = ins_q;
  assign bus.ins_valid   = vld_q;
  assign bus.pc          = pc_q;
  assign bus.load_count  = cnt_q;
  assign bus.load_ovf    = ovf_q;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl with a 256-entry behavioural instruction memory.
module tb_ins_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  ins_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ins_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .TERM(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.stall       = 1'b0;
    bus.branch      = 1'b0;
    bus.branch_addr = '0;
    bus.halt        = 1'b0;
    bus.restart     = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_pc",    32'(bus.pc), 32'h0);
    chk("rst_cnt",   32'(bus.load_count), 32'h0);
    chk("rst_ovf",   32'(bus.load_ovf), 32'h0);
    chk("rst_ins",   32'(bus.instruction), 32'h0);
    chk("rst_vld",   32'(bus.ins_valid), 32'h0);
    chk("rst_run",   32'(bus.running), 32'h0);
    chk("rst_halt",  32'(bus.halted), 32'h0);
    chk("rst_ready", 32'(bus.load_ready), 32'h1);

    // Load 40 5F FF
    bus.load_valid = 1'b1; bus.load_data = 8'h40;
    #1 chk("ld0_we", 32'(bus.mem_we), 32'h1);
    chk("ld0_addr", 32'(bus.mem_waddr), 32'h0);
    step();
    bus.load_data = 8'h5F;
    #1 chk("ld1_addr", 32'(bus.mem_waddr), 32'h1);
    step();
    bus.load_data = 8'hFF;
    #1 chk("ld2_addr", 32'(bus.mem_waddr), 32'h2);
    step();
    bus.load_valid = 1'b0;
    #1;
    chk("ld_cnt",   32'(bus.load_count), 32'd3);
    chk("ld_run",   32'(bus.running), 32'h1);
    chk("ld_ovf",   32'(bus.load_ovf), 32'h0);
    chk("ld_ready", 32'(bus.load_ready), 32'h0);
    chk("ld_we",    32'(bus.mem_we), 32'h0);
    chk("ld_m0",    32'(mem[0]), 32'h40);
    chk("ld_m1",    32'(mem[1]), 32'h5F);
    chk("ld_m2",    32'(mem[2]), 32'hFF);

    // Sequential fetch
    step();
    chk("f0_ins", 32'(bus.instruction), 32'h40);
    chk("f0_vld", 32'(bus.ins_valid), 32'h1);
    chk("f0_pc",  32'(bus.pc), 32'h1);
    step();
    chk("f1_ins", 32'(bus.instruction), 32'h5F);
    chk("f1_pc",  32'(bus.pc), 32'h2);
    step();
    chk("f2_ins", 32'(bus.instruction), 32'hFF);
    chk("f2_pc",  32'(bus.pc), 32'h3);
    for (int i = 0; i < 8; i++) step();
    chk("pre_br_pc",  32'(bus.pc), 32'h0B);
    chk("pre_br_ins", 32'(bus.instruction), 32'h1A);

    // Branch to 0x0E
    bus.branch = 1'b1; bus.branch_addr = 8'h0E;
    step();
    bus.branch = 1'b0;
    chk("br_pc",  32'(bus.pc), 32'h0E);
    chk("br_vld", 32'(bus.ins_valid), 32'h0);
    chk("br_ins", 32'(bus.instruction), 32'h1A);
    step();
    chk("br_tgt_ins", 32'(bus.instruction), 32'h1E);
    chk("br_tgt_vld", 32'(bus.ins_valid), 32'h1);
    chk("br_tgt_pc",  32'(bus.pc), 32'h0F);

    // Stall for 3 cycles
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc",  32'(bus.pc), 32'h0F);
      chk("st_ins", 32'(bus.instruction), 32'h1E);
      chk("st_vld", 32'(bus.ins_valid), 32'h1);
    end
    bus.stall = 1'b0;
    step();
    chk("unst_ins", 32'(bus.instruction), 32'h1F);
    chk("unst_pc",  32'(bus.pc), 32'h10);

    // Halt beats branch
    bus.halt = 1'b1; bus.branch = 1'b1; bus.branch_addr = 8'h33;
    step();
    bus.halt = 1'b0; bus.branch = 1'b0;
    chk("h_halted", 32'(bus.halted), 32'h1);
    chk("h_run",    32'(bus.running), 32'h0);
    chk("h_pc",     32'(bus.pc), 32'h10);
    chk("h_vld",    32'(bus.ins_valid), 32'h0);
    chk("h_ins",    32'(bus.instruction), 32'h1F);
    step();
    chk("h_hold", 32'(bus.halted), 32'h1);
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    chk("rs_ready",  32'(bus.load_ready), 32'h1);
    chk("rs_cnt",    32'(bus.load_count), 32'h0);
    chk("rs_pc",     32'(bus.pc), 32'h0);
    chk("rs_halted", 32'(bus.halted), 32'h0);

    // 256 zero bytes, no terminator
    bus.load_valid = 1'b1; bus.load_data = 8'h00;
    for (int i = 0; i < 255; i++) step();
    chk("ov_last_addr", 32'(bus.mem_waddr), 32'hFF);
    chk("ov_last_run",  32'(bus.running), 32'h0);
    step();
    bus.load_valid = 1'b0;
    chk("ov_flag", 32'(bus.load_ovf), 32'h1);
    chk("ov_cnt",  32'(bus.load_count), 32'd256);
    chk("ov_run",  32'(bus.running), 32'h1);
    chk("ov_mem",  32'(mem[8'h80]), 32'h0);

    // Free-run fetch across the PC wrap
    for (int i = 0; i < 255; i++) step();
    chk("wr_pc_ff", 32'(bus.pc), 32'hFF);
    step();
    chk("wr_pc_00", 32'(bus.pc), 32'h00);
    chk("wr_ins",   32'(bus.instruction), 32'h00);
    chk("wr_vld",   32'(bus.ins_valid), 32'h1);

    // Back to LOAD, reset mid-load
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0; bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    bus.load_valid = 1'b1; bus.load_data = 8'h11; bus.halt = 1'b1;
    step();
    bus.halt = 1'b0; bus.load_data = 8'h22;
    step();
    bus.load_valid = 1'b0;
    chk("ml_cnt",   32'(bus.load_count), 32'd2);
    chk("ml_ready", 32'(bus.load_ready), 32'h1);
    chk("ml_m1",    32'(mem[1]), 32'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_cnt",   32'(bus.load_count), 32'h0);
    chk("mr_ready", 32'(bus.load_ready), 32'h1);
    bus.load_valid = 1'b1; bus.load_data = 8'hAA;
    #1 chk("mr_addr", 32'(bus.mem_waddr), 32'h0);
    step();
    chk("mr_m0",  32'(mem[0]), 32'hAA);
    chk("mr_cnt1", 32'(bus.load_count), 32'd1);
    bus.load_data = 8'hFF;
    step();
    bus.load_valid = 1'b0;
    chk("mr_run",  32'(bus.running), 32'h1);
    chk("mr_cnt2", 32'(bus.load_count), 32'd2);
    step();
    chk("mr_ins", 32'(bus.instruction), 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
